// File: rtl/mac_sequencer_if.sv
// Operand stream, multiplier link and result stream of the MAC sequencer.
// The slave view belongs to mac_sequencer and the master view to whatever surrounds it.
interface mac_sequencer_if #(parameter int ACC_W = 20);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_a;
   logic [7:0]       in_b;
   logic             in_last;
   logic             mul_start;
   logic [7:0]       mul_a;
   logic [7:0]       mul_b;
   logic [15:0]      mul_product;
   logic             mul_ready;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [7:0]       out_count;
   logic             out_overflow;

   modport slave (
      input  in_valid, in_a, in_b, in_last, mul_product, mul_ready, out_ready,
      output in_ready, mul_start, mul_a, mul_b, out_valid, out_sum, out_count, out_overflow
   );

   modport master (
      output in_valid, in_a, in_b, in_last, mul_product, mul_ready, out_ready,
      input  in_ready, mul_start, mul_a, mul_b, out_valid, out_sum, out_count, out_overflow
   );
endinterface

// File: rtl/mac_sequencer.sv
// Feeds signed operand pairs one at a time to the shift-add multiplier and accumulates
// the products into a dot-product result with saturating term count and sticky overflow.
module mac_sequencer #(
   parameter int ACC_W = 20
) (
   input  logic           clk,
   input  logic           rst,
   mac_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   state_t           state_q,     state_d;
   logic             in_ready_q,  in_ready_d;
   logic             mul_start_q, mul_start_d;
   logic [7:0]       mul_a_q,     mul_a_d;
   logic [7:0]       mul_b_q,     mul_b_d;
   logic             last_q,      last_d;
   logic [ACC_W-1:0] acc_q,       acc_d;
   logic [7:0]       count_q,     count_d;
   logic             ovf_q,       ovf_d;
   logic             out_valid_q, out_valid_d;

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] sum;
   logic             add_ovf;

   // Signed overflow: both addends share a sign and the wrapped sum does not.
   always_comb begin
      prod_ext = ACC_W'($signed(bus.mul_product));
      sum      = acc_q + prod_ext;
      add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
   end

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      mul_start_d = 1'b0;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      last_d      = last_q;
      acc_d       = acc_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mul_a_d     = bus.in_a;
               mul_b_d     = bus.in_b;
               last_d      = bus.in_last;
               mul_start_d = 1'b1;
               in_ready_d  = 1'b0;
               state_d     = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // mul_ready is only looked at here, so a stale or undefined done flag cannot leak in.
            if (bus.mul_ready) begin
               acc_d   = sum;
               count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
               ovf_d   = ovf_q | add_ovf;
               if (last_q) begin
                  out_valid_d = 1'b1;
                  state_d     = OUT;
               end else begin
                  in_ready_d = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               acc_d       = '0;
               count_d     = '0;
               ovf_d       = 1'b0;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         last_q      <= 1'b0;
         acc_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         mul_start_q <= mul_start_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         last_q      <= last_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.mul_start    = mul_start_q;
   assign bus.mul_a        = mul_a_q;
   assign bus.mul_b        = mul_b_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_sum      = acc_q;
   assign bus.out_count    = count_q;
   assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Runs a 20-bit and a 16-bit accumulator side by side on the same stimulus, with a
// cycle-level multiplier stand-in and a dot-product reference model built from exact integer sums.
module tb_mac_sequencer;
   localparam int CYC_LIMIT = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;
   logic        mul_ready;
   logic [15:0] mul_product;

   mac_sequencer_if #(.ACC_W(20)) bus20 ();
   mac_sequencer_if #(.ACC_W(16)) bus16 ();

   assign bus20.in_valid    = in_valid;
   assign bus20.in_a        = in_a;
   assign bus20.in_b        = in_b;
   assign bus20.in_last     = in_last;
   assign bus20.out_ready   = out_ready;
   assign bus20.mul_ready   = mul_ready;
   assign bus20.mul_product = mul_product;
   assign bus16.in_valid    = in_valid;
   assign bus16.in_a        = in_a;
   assign bus16.in_b        = in_b;
   assign bus16.in_last     = in_last;
   assign bus16.out_ready   = out_ready;
   assign bus16.mul_ready   = mul_ready;
   assign bus16.mul_product = mul_product;

   mac_sequencer #(.ACC_W(20)) dut20 (.clk(clk), .rst(rst), .bus(bus20));
   mac_sequencer #(.ACC_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int last_accept = 0;
   bit expect_ready_now = 1'b0;
   logic       pre_valid = 1'b0;
   logic [7:0] pre_a = '0;
   logic [7:0] pre_b = '0;
   logic       pre_last = 1'b0;
   int terms[$];
   logic [19:0] exp_sum20;
   logic [15:0] exp_sum16;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Multiplier stand-in: done flag undefined until the first start, rises 9 cycles after start.
   initial begin : mul_model
      int cnt;
      logic start_seen;
      logic [15:0] res;
      cnt = 0;
      res = '0;
      mul_ready = 1'bx;
      mul_product = 'x;
      forever begin
         @(negedge clk);
         start_seen = (bus20.mul_start === 1'b1);
         if (start_seen) res = 16'(int'($signed(bus20.mul_a)) * int'($signed(bus20.mul_b)));
         @(posedge clk);
         #1;
         if (start_seen) begin
            cnt = 1;
            mul_ready = 1'b0;
            mul_product = 16'($urandom);
         end else if (cnt >= 1 && cnt <= 8) begin
            cnt++;
            if (cnt == 9) begin
               mul_ready = 1'b1;
               mul_product = res;
            end
         end
      end
   end

   function automatic void expect_sum(input int w, output longint sum, output bit ovf);
      longint hi = (longint'(1) << (w - 1)) - 1;
      longint lo = -(longint'(1) << (w - 1));
      longint mask = (longint'(1) << w) - 1;
      sum = 0;
      ovf = 1'b0;
      foreach (terms[i]) begin
         sum = sum + terms[i];
         if (sum > hi || sum < lo) ovf = 1'b1;
         sum = sum & mask;
         if (sum > hi) sum = sum - (longint'(1) << w);
      end
   endfunction

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      pre_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      terms.delete();
      expect_ready_now = 1'b1;
   endtask

   // Present one pair (entered just after a rising edge) and check the 10 cycles after acceptance.
   task automatic issue_term(input logic [7:0] a, input logic [7:0] b, input bit last);
      int waited;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_last = last;
      @(negedge clk);
      if (expect_ready_now) begin
         n_vec++;
         if (bus20.in_ready !== 1'b1 || bus16.in_ready !== 1'b1 || bus20.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ready_return: in_ready20=%b in_ready16=%b out_valid=%b, expected 1 1 0",
                     bus20.in_ready, bus16.in_ready, bus20.out_valid);
         end
         expect_ready_now = 1'b0;
      end
      waited = 0;
      while (bus20.in_ready !== 1'b1) begin
         if (waited == CYC_LIMIT) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected it to rise", waited);
            finish_run();
         end
         @(negedge clk);
         waited++;
      end
      last_accept = cyc;
      terms.push_back(int'($signed(a)) * int'($signed(b)));
      tick();
      in_valid = pre_valid;
      in_a = pre_a;
      in_b = pre_b;
      in_last = pre_last;
      pre_valid = 1'b0;
      for (int off = 1; off <= 10; off++) begin
         @(negedge clk);
         n_vec++;
         if ({bus20.mul_start, bus16.mul_start, bus20.in_ready, bus16.in_ready, bus20.out_valid}
             !== {(off == 1), (off == 1), 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL issue_timing k+%0d: start=%b/%b in_ready=%b/%b out_valid=%b, expected start=%b in_ready=0 out_valid=0",
                     off, bus20.mul_start, bus16.mul_start, bus20.in_ready, bus16.in_ready,
                     bus20.out_valid, (off == 1));
         end
         if (off == 10) begin
            n_vec++;
            if ({bus20.mul_a, bus20.mul_b, bus16.mul_a, bus16.mul_b} !== {a, b, a, b}) begin
               n_err++;
               $display("FAIL operand_hold: mul_a=%h mul_b=%h, expected %h %h", bus20.mul_a, bus20.mul_b, a, b);
            end
         end
      end
      tick();
      expect_ready_now = !last;
   endtask

   // Check the result in the cycle it first appears, then step to the next cycle.
   task automatic check_result();
      longint s20, s16;
      bit o20, o16;
      int c;
      expect_sum(20, s20, o20);
      expect_sum(16, s16, o16);
      c = (terms.size() > 255) ? 255 : terms.size();
      exp_sum20 = 20'(s20);
      exp_sum16 = 16'(s16);
      @(negedge clk);
      n_vec++;
      if ({bus20.out_valid, bus20.in_ready, bus20.out_sum, bus20.out_count, bus20.out_overflow}
          !== {1'b1, 1'b0, exp_sum20, 8'(c), o20}) begin
         n_err++;
         $display("FAIL result20: valid=%b in_ready=%b sum=%0d count=%0d ovf=%b, expected 1 0 %0d %0d %b",
                  bus20.out_valid, bus20.in_ready, $signed(bus20.out_sum), bus20.out_count,
                  bus20.out_overflow, s20, c, o20);
      end
      n_vec++;
      if ({bus16.out_valid, bus16.in_ready, bus16.out_sum, bus16.out_count, bus16.out_overflow}
          !== {1'b1, 1'b0, exp_sum16, 8'(c), o16}) begin
         n_err++;
         $display("FAIL result16: valid=%b in_ready=%b sum=%0d count=%0d ovf=%b, expected 1 0 %0d %0d %b",
                  bus16.out_valid, bus16.in_ready, $signed(bus16.out_sum), bus16.out_count,
                  bus16.out_overflow, s16, c, o16);
      end
      terms.delete();
      expect_ready_now = (out_ready === 1'b1);
      tick();
   endtask

   task automatic run_vector(input int n, input bit b2b);
      logic [7:0] qa[$];
      logic [7:0] qb[$];
      for (int i = 0; i < n; i++) begin
         qa.push_back(8'($urandom));
         qb.push_back(8'($urandom));
      end
      for (int i = 0; i < n; i++) begin
         if (b2b && i + 1 < n) begin
            pre_valid = 1'b1;
            pre_a = qa[i+1];
            pre_b = qb[i+1];
            pre_last = (i + 2 == n);
         end else if (!b2b) begin
            repeat ($urandom_range(0, 3)) tick();
         end
         issue_term(qa[i], qb[i], i == n - 1);
      end
      check_result();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_vec++;
      if ({bus20.in_ready, bus20.mul_start, bus20.mul_a, bus20.mul_b, bus20.out_valid,
           bus20.out_sum, bus20.out_count, bus20.out_overflow} !== {1'b1, 1'b0, 16'h0, 1'b0, 20'h0, 8'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset20: ready=%b start=%b a=%h b=%h valid=%b sum=%h count=%h ovf=%b, expected 1 0 00 00 0 0 0 0",
                  bus20.in_ready, bus20.mul_start, bus20.mul_a, bus20.mul_b, bus20.out_valid,
                  bus20.out_sum, bus20.out_count, bus20.out_overflow);
      end
      n_vec++;
      if ({bus16.in_ready, bus16.mul_start, bus16.out_valid, bus16.out_sum, bus16.out_count,
           bus16.out_overflow} !== {1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset16: ready=%b start=%b valid=%b sum=%h count=%h ovf=%b, expected 1 0 0 0 0 0",
                  bus16.in_ready, bus16.mul_start, bus16.out_valid, bus16.out_sum, bus16.out_count,
                  bus16.out_overflow);
      end
      tick();
   endtask

   task automatic test_single();
      issue_term(8'h80, 8'h80, 1'b1);
      check_result();
   endtask

   task automatic test_back_to_back();
      int t0, t1;
      pre_valid = 1'b1; pre_a = 8'(-5); pre_b = 8'd7; pre_last = 1'b0;
      issue_term(8'd3, 8'd4, 1'b0);
      t0 = last_accept;
      pre_valid = 1'b1; pre_a = 8'd127; pre_b = 8'(-1); pre_last = 1'b1;
      issue_term(8'(-5), 8'd7, 1'b0);
      t1 = last_accept;
      issue_term(8'd127, 8'(-1), 1'b1);
      n_vec++;
      if ((t1 - t0) !== 11 || (last_accept - t1) !== 11) begin
         n_err++;
         $display("FAIL b2b_spacing: gaps %0d and %0d cycles, expected 11 and 11", t1 - t0, last_accept - t1);
      end
      check_result();
   endtask

   task automatic test_backpressure();
      int j;
      out_ready = 1'b0;
      pre_valid = 1'b1; pre_a = 8'd9; pre_b = 8'(-9); pre_last = 1'b1;
      issue_term(8'd50, 8'd60, 1'b1);
      check_result();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++;
         if ({bus20.in_ready, bus20.out_valid, bus20.out_sum, bus16.out_sum} !== {1'b0, 1'b1, exp_sum20, exp_sum16}) begin
            n_err++;
            $display("FAIL backpressure_hold: in_ready=%b out_valid=%b sum=%0d, expected 0 1 %0d",
                     bus20.in_ready, bus20.out_valid, $signed(bus20.out_sum), $signed(exp_sum20));
         end
         tick();
      end
      out_ready = 1'b1;
      j = cyc;
      @(negedge clk);
      n_vec++;
      if ({bus20.in_ready, bus20.out_valid, bus20.out_sum} !== {1'b0, 1'b1, exp_sum20}) begin
         n_err++;
         $display("FAIL handshake_cycle: in_ready=%b out_valid=%b sum=%0d, expected 0 1 %0d",
                  bus20.in_ready, bus20.out_valid, $signed(bus20.out_sum), $signed(exp_sum20));
      end
      tick();
      expect_ready_now = 1'b1;
      issue_term(8'd9, 8'(-9), 1'b1);
      n_vec++;
      if (last_accept !== j + 1) begin
         n_err++;
         $display("FAIL bp_accept_cycle: accepted at %0d, expected %0d", last_accept, j + 1);
      end
      check_result();
   endtask

   task automatic test_overflow();
      issue_term(8'h80, 8'h80, 1'b0);
      issue_term(8'h80, 8'h80, 1'b0);
      issue_term(8'h80, 8'h80, 1'b1);
      check_result();
      n_vec++;
      if (exp_sum16 !== 16'hC000 || bus16.out_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL ovf16_model_or_clear: model sum=%h, ovf after take=%b, expected C000 0",
                  exp_sum16, bus16.out_overflow);
      end
      issue_term(8'd1, 8'd1, 1'b1);
      check_result();
   endtask

   task automatic test_reset_mid_wait();
      in_valid = 1'b1; in_a = 8'd100; in_b = 8'd100; in_last = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus20.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL abort_accept: in_ready=%b, expected 1", bus20.in_ready);
      end
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      terms.delete();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_vec++;
         if ({bus20.in_ready, bus20.out_valid, bus20.out_sum, bus20.out_count, bus16.out_sum}
             !== {1'b1, 1'b0, 20'h0, 8'h0, 16'h0}) begin
            n_err++;
            $display("FAIL abort_idle +%0d: in_ready=%b out_valid=%b sum=%0d count=%0d, expected 1 0 0 0",
                     i, bus20.in_ready, bus20.out_valid, $signed(bus20.out_sum), bus20.out_count);
         end
      end
      tick();
      issue_term(8'd2, 8'd3, 1'b1);
      check_result();
   endtask

   task automatic test_count_saturation();
      run_vector(257, 1'b1);
   endtask

   task automatic test_random();
      for (int v = 0; v < 12; v++) run_vector(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
   endtask

   initial begin
      #2000000;
      n_vec++;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_run();
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_reset_mid_wait();
      test_count_saturation();
      test_random();
      finish_run();
   end
endmodule
